id_ex_stage: RTL and testbench

- Pipeline register and operand-select stage that sits directly upstream of the ALU.
- Captures the decoded instruction from ID and resolves data forwarding from EX/MEM and MEM/WB.
- Drives the ALU operands src1/src2 and the 4-bit ALU control code.
- Detects load-use hazards and inserts bubbles. Handles branch flush.

---
 rtl/id_ex_stage.sv | 174 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, load-use stall and flush
// Operand-select stage feeding the ALU; forwarding is resolved combinationally on the outputs.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          id_valid_i,
  input  logic [AW-1:0] id_rs_i,
  input  logic [AW-1:0] id_rt_i,
  input  logic [AW-1:0] id_dst_i,
  input  logic [DW-1:0] id_rs_data_i,
  input  logic [DW-1:0] id_rt_data_i,
  input  logic [DW-1:0] id_imm_i,
  input  logic [3:0]    id_alu_ctrl_i,
  input  logic          id_alu_src_i,
  input  logic          id_reg_write_i,
  input  logic          id_mem_read_i,
  input  logic          id_mem_write_i,
  input  logic          flush_i,
  input  logic          exmem_reg_write_i,
  input  logic [AW-1:0] exmem_dst_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic          memwb_reg_write_i,
  input  logic [AW-1:0] memwb_dst_i,
  input  logic [DW-1:0] memwb_data_i,
  output logic          stall_o,
  output logic          ex_valid_o,
  output logic [DW-1:0] ex_src1_o,
  output logic [DW-1:0] ex_src2_o,
  output logic [3:0]    ex_alu_ctrl_o,
  output logic [DW-1:0] ex_store_data_o,
  output logic [AW-1:0] ex_dst_o,
  output logic          ex_reg_write_o,
  output logic          ex_mem_read_o,
  output logic          ex_mem_write_o
);

  localparam logic [3:0] CTRL_SRA  = 4'd8;
  localparam logic [3:0] CTRL_SRAV = 4'd9;
  localparam logic [3:0] CTRL_LUI  = 4'd10;

  logic          valid_q,     valid_d;
  logic [AW-1:0] rs_q,        rs_d;
  logic [AW-1:0] rt_q,        rt_d;
  logic [AW-1:0] dst_q,       dst_d;
  logic [DW-1:0] rs_data_q,   rs_data_d;
  logic [DW-1:0] rt_data_q,   rt_data_d;
  logic [DW-1:0] imm_q,       imm_d;
  logic [3:0]    alu_ctrl_q,  alu_ctrl_d;
  logic          alu_src_q,   alu_src_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q,  mem_read_d;
  logic          mem_write_q, mem_write_d;

  logic          hz;
  logic          bypass_rs, bypass_rt;
  logic [DW-1:0] fwd_a, fwd_b;
  logic [DW-1:0] src1, src2;

  assign hz = valid_q && mem_read_q && (dst_q != '0) && id_valid_i &&
              ((dst_q == id_rs_i) || (dst_q == id_rt_i));
  assign stall_o = hz && !flush_i;

  // A write landing in the register file this same cycle would be missed by ID's read.
  assign bypass_rs = memwb_reg_write_i && (memwb_dst_i != '0) && (memwb_dst_i == id_rs_i);
  assign bypass_rt = memwb_reg_write_i && (memwb_dst_i != '0) && (memwb_dst_i == id_rt_i);

  always_comb begin
    valid_d     = id_valid_i;
    rs_d        = id_rs_i;
    rt_d        = id_rt_i;
    dst_d       = id_dst_i;
    rs_data_d   = bypass_rs ? memwb_data_i : id_rs_data_i;
    rt_data_d   = bypass_rt ? memwb_data_i : id_rt_data_i;
    imm_d       = id_imm_i;
    alu_ctrl_d  = id_alu_ctrl_i;
    alu_src_d   = id_alu_src_i;
    reg_write_d = id_reg_write_i;
    mem_read_d  = id_mem_read_i;
    mem_write_d = id_mem_write_i;
    if (flush_i || hz) begin
      valid_d     = 1'b0;
      rs_d        = '0;
      rt_d        = '0;
      dst_d       = '0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      alu_ctrl_d  = '0;
      alu_src_d   = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      dst_q       <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_ctrl_q  <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      dst_q       <= dst_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // EX/MEM holds the younger result, so it wins over MEM/WB.
  always_comb begin
    fwd_a = rs_data_q;
    if (exmem_reg_write_i && (exmem_dst_i != '0) && (exmem_dst_i == rs_q))
      fwd_a = exmem_result_i;
    else if (memwb_reg_write_i && (memwb_dst_i != '0) && (memwb_dst_i == rs_q))
      fwd_a = memwb_data_i;

    fwd_b = rt_data_q;
    if (exmem_reg_write_i && (exmem_dst_i != '0) && (exmem_dst_i == rt_q))
      fwd_b = exmem_result_i;
    else if (memwb_reg_write_i && (memwb_dst_i != '0) && (memwb_dst_i == rt_q))
      fwd_b = memwb_data_i;
  end

  always_comb begin
    src1 = fwd_a;
    src2 = alu_src_q ? imm_q : fwd_b;
    case (alu_ctrl_q)
      CTRL_SRA: begin
        src1 = imm_q;
        src2 = fwd_b;
      end
      CTRL_SRAV: begin
        src1 = fwd_a;
        src2 = fwd_b;
      end
      CTRL_LUI: begin
        src1 = '0;
        src2 = imm_q;
      end
      default: ;
    endcase
  end

  assign ex_valid_o      = valid_q;
  assign ex_src1_o       = valid_q ? src1  : '0;
  assign ex_src2_o       = valid_q ? src2  : '0;
  assign ex_store_data_o = valid_q ? fwd_b : '0;
  assign ex_alu_ctrl_o   = alu_ctrl_q;
  assign ex_dst_o        = dst_q;
  assign ex_reg_write_o  = reg_write_q;
  assign ex_mem_read_o   = mem_read_q;
  assign ex_mem_write_o  = mem_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
// Directed table, hand-written hazard sequences, then randomized traffic against a reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic        flush;
  logic        em_we;
  logic [4:0]  em_dst;
  logic [31:0] em_res;
  logic        mw_we;
  logic [4:0]  mw_dst;
  logic [31:0] mw_data;
  logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_src1, ex_src2, ex_store;
  logic [3:0]  ex_ctrl;
  logic [4:0]  ex_dst;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .AW(5)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_dst_i(id_dst),
    .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data), .id_imm_i(id_imm),
    .id_alu_ctrl_i(id_alu_ctrl), .id_alu_src_i(id_alu_src),
    .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .id_mem_write_i(id_mem_write),
    .flush_i(flush),
    .exmem_reg_write_i(em_we), .exmem_dst_i(em_dst), .exmem_result_i(em_res),
    .memwb_reg_write_i(mw_we), .memwb_dst_i(mw_dst), .memwb_data_i(mw_data),
    .stall_o(stall), .ex_valid_o(ex_valid), .ex_src1_o(ex_src1), .ex_src2_o(ex_src2),
    .ex_alu_ctrl_o(ex_ctrl), .ex_store_data_o(ex_store), .ex_dst_o(ex_dst),
    .ex_reg_write_o(ex_reg_write), .ex_mem_read_o(ex_mem_read), .ex_mem_write_o(ex_mem_write)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; id_valid = 0;
    id_rs = 0; id_rt = 0; id_dst = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_alu_ctrl = 0; id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    em_we = 0; em_dst = 0; em_res = 0; mw_we = 0; mw_dst = 0; mw_data = 0;
  endtask

  task automatic present(input logic [3:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dst, input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [31:0] imm, input logic asrc, input logic mr);
    id_valid = 1; id_alu_ctrl = ctrl; id_rs = rs; id_rt = rt; id_dst = dst;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alu_src = asrc;
    id_reg_write = 1; id_mem_read = mr; id_mem_write = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 0);
    chk({tag, "_src1"}, ex_src1, 0);
    chk({tag, "_src2"}, ex_src2, 0);
    chk({tag, "_store"}, ex_store, 0);
    chk({tag, "_ctrl"}, {28'd0, ex_ctrl}, 0);
    chk({tag, "_ctl"}, {27'd0, ex_dst, ex_reg_write, ex_mem_read, ex_mem_write}, 0);
    chk({tag, "_stall"}, {31'd0, stall}, 0);
  endtask

  typedef struct {
    logic [3:0]  ctrl;
    logic [4:0]  rs, rt;
    logic [31:0] rsd, rtd, imm;
    logic        asrc;
    logic        cw; logic [4:0] cd; logic [31:0] cv;
    logic        ew; logic [4:0] ed; logic [31:0] ev;
    logic        ww; logic [4:0] wd; logic [31:0] wv;
    logic [31:0] e1, e2, es;
  } vec_t;

  vec_t tbl[10];

  // Reference model: what EX currently holds, in architectural terms.
  logic        m_valid, m_asrc, m_rw, m_mr, m_mw;
  logic [4:0]  m_rs, m_rt, m_dst;
  logic [31:0] m_rsd, m_rtd, m_imm;
  logic [3:0]  m_ctrl;

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] stored);
    if (r == 0) return stored;
    if (em_we && em_dst == r) return em_res;
    if (mw_we && mw_dst == r) return mw_data;
    return stored;
  endfunction

  task automatic model_check();
    logic [31:0] a, b, s1, s2;
    logic hz;
    a = fwd(m_rs, m_rsd);
    b = fwd(m_rt, m_rtd);
    if (m_ctrl == 8)       begin s1 = m_imm; s2 = b;     end
    else if (m_ctrl == 9)  begin s1 = a;     s2 = b;     end
    else if (m_ctrl == 10) begin s1 = 0;     s2 = m_imm; end
    else                   begin s1 = a;     s2 = m_asrc ? m_imm : b; end
    if (!m_valid) begin s1 = 0; s2 = 0; b = 0; end
    hz = m_valid && m_mr && m_dst != 0 && id_valid && (m_dst == id_rs || m_dst == id_rt);
    chk("rnd_stall", {31'd0, stall}, {31'd0, hz && !flush});
    chk("rnd_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    chk("rnd_src1", ex_src1, s1);
    chk("rnd_src2", ex_src2, s2);
    chk("rnd_store", ex_store, b);
    chk("rnd_ctrl", {28'd0, ex_ctrl}, {28'd0, m_ctrl});
    chk("rnd_ctl", {27'd0, ex_dst, ex_reg_write, ex_mem_read, ex_mem_write},
        {27'd0, m_dst, m_rw, m_mr, m_mw});
  endtask

  task automatic model_step();
    logic hz;
    hz = m_valid && m_mr && m_dst != 0 && id_valid && (m_dst == id_rs || m_dst == id_rt);
    if (rst || flush || hz) begin
      m_valid = 0; m_rs = 0; m_rt = 0; m_dst = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
      m_ctrl = 0; m_asrc = 0; m_rw = 0; m_mr = 0; m_mw = 0;
    end else begin
      m_valid = id_valid; m_rs = id_rs; m_rt = id_rt; m_dst = id_dst; m_imm = id_imm;
      m_rsd = (mw_we && mw_dst != 0 && mw_dst == id_rs) ? mw_data : id_rs_data;
      m_rtd = (mw_we && mw_dst != 0 && mw_dst == id_rt) ? mw_data : id_rt_data;
      m_ctrl = id_alu_ctrl; m_asrc = id_alu_src;
      m_rw = id_reg_write; m_mr = id_mem_read; m_mw = id_mem_write;
    end
  endtask

  initial begin
    //          ctrl rs  rt  rsd          rtd          imm          as cw cd cv     ew ed ev      ww wd wv     e1           e2           es
    tbl[0] = '{4'd4,  5'd1, 5'd2, 32'h5,    32'h7,        32'h0,        1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h5,    32'h7,        32'h7};
    tbl[1] = '{4'd4,  5'd3, 5'd2, 32'h33,   32'h7,        32'h0,        1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h100, 1'b1, 5'd3, 32'h200, 32'h100,  32'h7,        32'h7};
    tbl[2] = '{4'd4,  5'd0, 5'd0, 32'h44,   32'h55,       32'h0,        1'b0, 1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h100, 1'b1, 5'd0, 32'h200, 32'h44,   32'h55,       32'h55};
    tbl[3] = '{4'd4,  5'd4, 5'd5, 32'h11,   32'h66,       32'h0,        1'b0, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h22,   32'h66,       32'h66};
    tbl[4] = '{4'd8,  5'd6, 5'd7, 32'hDEAD, 32'hF0000000, 32'h2C0,      1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h2C0,  32'hF0000000, 32'hF0000000};
    tbl[5] = '{4'd10, 5'd1, 5'd9, 32'h5,    32'h77,       32'h1234,     1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h0,    32'h1234,     32'h77};
    tbl[6] = '{4'd5,  5'd2, 5'd3, 32'd10,   32'd20,       32'hFFFFFFF0, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'd10,   32'hFFFFFFF0, 32'd20};
    tbl[7] = '{4'd9,  5'd2, 5'd3, 32'd3,    32'h80,       32'h1,        1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   1'b1, 5'd3, 32'hAB,  32'd3,    32'hAB,       32'hAB};
    tbl[8] = '{4'd13, 5'd1, 5'd2, 32'd1,    32'd2,        32'h0,        1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd2, 32'hC0,  1'b0, 5'd0, 32'h0,   32'd1,    32'hC0,       32'hC0};
    tbl[9] = '{4'd6,  5'd5, 5'd6, 32'h0,    32'h0,        32'h0,        1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 32'hE,   1'b1, 5'd5, 32'hF,   32'hF,    32'hE,        32'hE};

    idle();
    // Reset with arbitrary inputs for two cycles
    rst = 1;
    present(4'd5, 5'd3, 5'd3, 5'd3, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h1, 1'b1, 1'b1);
    flush = 1; em_we = 1; em_dst = 3; em_res = 32'h1; mw_we = 1; mw_dst = 3; mw_data = 32'h2;
    tick(); #1; chk_zero("rst1");
    tick(); #1; chk_zero("rst2");
    idle();

    foreach (tbl[i]) begin
      present(tbl[i].ctrl, tbl[i].rs, tbl[i].rt, 5'd10, tbl[i].rsd, tbl[i].rtd, tbl[i].imm,
              tbl[i].asrc, 1'b0);
      em_we = 0; em_dst = 0; em_res = 0;
      mw_we = tbl[i].cw; mw_dst = tbl[i].cd; mw_data = tbl[i].cv;
      tick();
      id_valid = 0;
      em_we = tbl[i].ew; em_dst = tbl[i].ed; em_res = tbl[i].ev;
      mw_we = tbl[i].ww; mw_dst = tbl[i].wd; mw_data = tbl[i].wv;
      #1;
      chk($sformatf("tbl%0d_src1", i), ex_src1, tbl[i].e1);
      chk($sformatf("tbl%0d_src2", i), ex_src2, tbl[i].e2);
      chk($sformatf("tbl%0d_store", i), ex_store, tbl[i].es);
      chk($sformatf("tbl%0d_ctrl", i), {28'd0, ex_ctrl}, {28'd0, tbl[i].ctrl});
      chk($sformatf("tbl%0d_valid", i), {31'd0, ex_valid}, 32'd1);
    end

    // Load-use: one stall cycle, bubble, then the re-presented SUBU takes the loaded value
    idle();
    present(4'd4, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h4, 1'b1, 1'b1);
    tick();
    present(4'd5, 5'd8, 5'd1, 5'd9, 32'h0, 32'h1, 32'h0, 1'b0, 1'b0);
    #1; chk("lu_stall", {31'd0, stall}, 32'd1);
    tick(); #1;
    chk("lu_stall_once", {31'd0, stall}, 32'd0);
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
    chk("lu_bubble_src1", ex_src1, 32'd0);
    mw_we = 1; mw_dst = 8; mw_data = 32'h5A5A;
    tick();
    mw_we = 0; id_valid = 0; #1;
    chk("lu_fwd_src1", ex_src1, 32'h5A5A);
    chk("lu_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_ctrl", {28'd0, ex_ctrl}, 32'd5);

    // Flush while a hazard is present
    present(4'd4, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h4, 1'b1, 1'b1);
    tick();
    present(4'd5, 5'd8, 5'd1, 5'd9, 32'h0, 32'h1, 32'h0, 1'b0, 1'b0);
    flush = 1; #1;
    chk("fl_stall", {31'd0, stall}, 32'd0);
    tick();
    flush = 0; id_valid = 0; #1;
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_dst", {27'd0, ex_dst}, 32'd0);
    chk("fl_rw", {31'd0, ex_reg_write}, 32'd0);

    // Reset during a stall
    present(4'd4, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h4, 1'b1, 1'b1);
    tick();
    present(4'd5, 5'd1, 5'd8, 5'd9, 32'h0, 32'h1, 32'h0, 1'b0, 1'b0);
    #1; chk("rs_stall_pre", {31'd0, stall}, 32'd1);
    rst = 1;
    tick(); #1;
    chk_zero("rs_mid");
    rst = 0;

    // Randomized traffic against the model, starting from a known reset state
    idle(); rst = 1;
    m_valid = 0;
    model_step();
    tick();
    for (int c = 0; c < 400; c++) begin
      rst          = ($urandom_range(0, 39) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      id_valid     = ($urandom_range(0, 5) != 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_dst       = 5'($urandom_range(0, 3));
      id_rs_data   = $urandom;
      id_rt_data   = $urandom;
      id_imm       = $urandom;
      id_alu_ctrl  = 4'($urandom_range(0, 15));
      id_alu_src   = 1'($urandom_range(0, 1));
      id_reg_write = 1'($urandom_range(0, 1));
      id_mem_read  = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom_range(0, 1));
      em_we        = 1'($urandom_range(0, 1));
      em_dst       = 5'($urandom_range(0, 3));
      em_res       = $urandom;
      mw_we        = 1'($urandom_range(0, 1));
      mw_dst       = 5'($urandom_range(0, 3));
      mw_data      = $urandom;
      #1;
      model_check();
      model_step();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
